// File: rtl/rle_channel_scheduler.sv
// Round-robin packet arbiter feeding one shared run-length encoder.
// Emits (symbol, run) pairs tagged with their source channel and an end-of-packet flag.
module rle_channel_scheduler #(
    parameter int NCH     = 4,
    parameter int MAX_RUN = 15,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH-1:0]   in_last,
    input  logic [8*NCH-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_symbol,
    output logic [3:0]       out_run,
    output logic [CW-1:0]    out_chan,
    output logic             out_last
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]    sym_q, sym_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_symbol_q, out_symbol_d;
    logic [3:0]    out_run_q, out_run_d;
    logic [CW-1:0] out_chan_q, out_chan_d;
    logic          out_last_q, out_last_d;

    logic          out_free;
    logic          loaded;
    logic [7:0]    data_arr [NCH];
    logic [7:0]    cur_data;
    logic          cur_valid;
    logic          cur_last;
    logic [2*NCH-1:0] req_dbl;
    logic [NCH-1:0]   req_rot;
    logic             grant_found;
    logic [CW-1:0]    grant_off;
    logic [CW:0]      grant_sum;
    logic [CW-1:0]    grant_chan;

    assign out_free = !out_valid_q || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign data_arr[gi] = in_data[8*gi +: 8];
            assign in_ready[gi] = (state_q == S_RUN) && (chan_q == CW'(gi)) && out_free;
        end
    endgenerate

    assign cur_data  = data_arr[chan_q];
    assign cur_valid = in_valid[chan_q];
    assign cur_last  = in_last[chan_q];

    // Rotate requests so bit 0 is the channel at rr_ptr; lowest set bit wins.
    assign req_dbl = {in_valid, in_valid};
    assign req_rot = req_dbl[rr_ptr_q +: NCH];

    always_comb begin
        grant_found = 1'b0;
        grant_off   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_found = 1'b1;
                grant_off   = CW'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
        if (grant_sum >= (CW+1)'(NCH)) begin
            grant_sum = grant_sum - (CW+1)'(NCH);
        end
        grant_chan = grant_sum[CW-1:0];
    end

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        rr_ptr_d     = rr_ptr_q;
        sym_d        = sym_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_symbol_d = out_symbol_q;
        out_run_d    = out_run_q;
        out_chan_d   = out_chan_q;
        out_last_d   = out_last_q;
        loaded       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    chan_d   = grant_chan;
                    rr_ptr_d = (grant_chan == CW'(NCH - 1)) ? '0 : grant_chan + 1'b1;
                    sym_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (cur_valid && out_free) begin
                    if (cnt_q == 4'd0) begin
                        sym_d = cur_data;
                        cnt_d = 4'd1;
                    end else if (cur_data == sym_q && cnt_q < 4'(MAX_RUN)) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_symbol_d = sym_q;
                        out_run_d    = cnt_q;
                        out_chan_d   = chan_q;
                        out_last_d   = 1'b0;
                        sym_d        = cur_data;
                        cnt_d        = 4'd1;
                        loaded       = 1'b1;
                    end
                    // A last byte that also closed a run leaves itself pending for FLUSH.
                    if (cur_last) begin
                        if (!loaded) begin
                            out_valid_d  = 1'b1;
                            out_symbol_d = sym_d;
                            out_run_d    = cnt_d;
                            out_chan_d   = chan_q;
                            out_last_d   = 1'b1;
                            cnt_d        = '0;
                            state_d      = S_IDLE;
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    out_valid_d  = 1'b1;
                    out_symbol_d = sym_q;
                    out_run_d    = 4'd1;
                    out_chan_d   = chan_q;
                    out_last_d   = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            chan_q       <= '0;
            rr_ptr_q     <= '0;
            sym_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_symbol_q <= '0;
            out_run_q    <= '0;
            out_chan_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            rr_ptr_q     <= rr_ptr_d;
            sym_q        <= sym_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_symbol_q <= out_symbol_d;
            out_run_q    <= out_run_d;
            out_chan_q   <= out_chan_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_symbol = out_symbol_q;
    assign out_run    = out_run_q;
    assign out_chan   = out_chan_q;
    assign out_last   = out_last_q;
endmodule

// File: tb/tb_rle_channel_scheduler.sv
// Directed bench for rle_channel_scheduler: per-channel byte queues feed the DUT,
// every output pair and packet completion is logged and compared to hand-computed lists.
module tb_rle_channel_scheduler;
    localparam int NCH     = 4;
    localparam int MAX_RUN = 15;
    localparam int CW      = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   in_valid = '0;
    logic [NCH-1:0]   in_last  = '0;
    logic [8*NCH-1:0] in_data  = '0;
    logic [NCH-1:0]   in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_symbol;
    logic [3:0]       out_run;
    logic [CW-1:0]    out_chan;
    logic             out_last;

    rle_channel_scheduler #(.NCH(NCH), .MAX_RUN(MAX_RUN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_symbol (out_symbol),
        .out_run    (out_run),
        .out_chan   (out_chan),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] s, input int r, input bit l, input int c);
        return {17'b0, 2'(c), l, s, 4'(r)};
    endfunction

    // Byte sources: {last, data} per entry, popped after an observed acceptance.
    logic [8:0]     src_q [NCH][$];
    logic [NCH-1:0] acc_pend = '0;
    logic [31:0]    got_q[$];
    logic [31:0]    exp_q[$];
    int             done_q[$];

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (acc_pend[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            if (src_q[c].size() > 0) begin
                in_valid[c]       = 1'b1;
                in_last[c]        = src_q[c][0][8];
                in_data[8*c +: 8] = src_q[c][0][7:0];
            end else begin
                in_valid[c]       = 1'b0;
                in_last[c]        = 1'b0;
                in_data[8*c +: 8] = 8'h00;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            acc_pend = '0;
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back(pk(out_symbol, int'(out_run), out_last, int'(out_chan)));
                $display("pair ch%0d sym=%02h run=%0d last=%0d", out_chan, out_symbol, out_run, out_last);
            end
            for (int c = 0; c < NCH; c++) begin
                acc_pend[c] = in_valid[c] && in_ready[c];
                if (acc_pend[c] && in_last[c]) done_q.push_back(c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int c, input logic [7:0] d, input bit last);
        src_q[c].push_back({last, d});
    endtask

    function automatic bit busy();
        bit b = out_valid || (in_ready != '0);
        for (int c = 0; c < NCH; c++) if (src_q[c].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_quiet(input string tag);
        int n = 0;
        while (busy() && n < 300) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(n < 300), 32'd1);
    endtask

    task automatic check_pairs(input string tag);
        check({tag, "_npairs"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_pair%0d", tag, i), (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_order(input string tag, input int exp_o[$]);
        check({tag, "_npkts"}, 32'(done_q.size()), 32'(exp_o.size()));
        for (int i = 0; i < exp_o.size(); i++)
            check($sformatf("%s_grant%0d", tag, i), (i < done_q.size()) ? 32'(done_q[i]) : 32'hFFFF_FFFF, 32'(exp_o[i]));
        done_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_fields", {17'b0, out_symbol, out_run, out_chan, out_last}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        step();

        // ch0: A,A,A,B(last)
        push(0, 8'h41, 0); push(0, 8'h41, 0); push(0, 8'h41, 0); push(0, 8'h42, 1);
        n = 0;
        while (!in_valid[0] && n < 10) begin step(); n++; end
        check("t1_ready_at_req", 32'(in_ready), 32'd0);
        step();
        check("t1_grant_next", 32'(in_ready), 32'b0001);
        wait_quiet("t1");
        exp_q.push_back(pk(8'h41, 3, 0, 0));
        exp_q.push_back(pk(8'h42, 1, 1, 0));
        check_pairs("t1");
        check_order("t1", '{0});

        // ch3: seventeen 0x55 bytes, saturating at MAX_RUN
        for (int i = 0; i < 17; i++) push(3, 8'h55, i == 16);
        wait_quiet("t2");
        check("t2_idle_ready", 32'(in_ready), 32'd0);
        exp_q.push_back(pk(8'h55, 15, 0, 3));
        exp_q.push_back(pk(8'h55, 2, 1, 3));
        check_pairs("t2");
        check_order("t2", '{3});

        // all channels at once, then ch0..2 re-request during ch3's turn
        for (int c = 0; c < NCH; c++) begin
            push(c, 8'(8'h10 + c), 0);
            push(c, 8'(8'h20 + c), 1);
        end
        n = 0;
        while (done_q.size() < 3 && n < 100) begin step(); n++; end
        for (int c = 0; c < 3; c++) begin
            push(c, 8'(8'h30 + c), 0);
            push(c, 8'(8'h30 + c), 1);
        end
        wait_quiet("t3");
        for (int c = 0; c < NCH; c++) begin
            exp_q.push_back(pk(8'(8'h10 + c), 1, 0, c));
            exp_q.push_back(pk(8'(8'h20 + c), 1, 1, c));
        end
        for (int c = 0; c < 3; c++) exp_q.push_back(pk(8'(8'h30 + c), 2, 1, c));
        check_pairs("t3");
        check_order("t3", '{0, 1, 2, 3, 0, 1, 2});

        // ch1 with a 5-cycle downstream stall after the first pair
        push(1, 8'hA0, 0); push(1, 8'hA0, 0); push(1, 8'hB1, 0);
        push(1, 8'hB1, 0); push(1, 8'hB1, 0); push(1, 8'hC2, 1);
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        out_ready = 1'b0;
        check("t4_snap", {19'b0, out_valid, out_symbol, out_run, out_chan, out_last},
              {19'b0, 1'b1, 8'hA0, 4'd2, 2'd1, 1'b0});
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t4_hold%0d", i), {19'b0, out_valid, out_symbol, out_run, out_chan, out_last},
                  {19'b0, 1'b1, 8'hA0, 4'd2, 2'd1, 1'b0});
            check($sformatf("t4_noready%0d", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        wait_quiet("t4");
        exp_q.push_back(pk(8'hA0, 2, 0, 1));
        exp_q.push_back(pk(8'hB1, 3, 0, 1));
        exp_q.push_back(pk(8'hC2, 1, 1, 1));
        check_pairs("t4");
        check_order("t4", '{1});

        // reset mid-packet on ch2 while a pair is stalled in the output register
        push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 0); push(2, 8'h44, 1);
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        src_q[2].delete();
        step();
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_fields", {17'b0, out_symbol, out_run, out_chan, out_last}, 32'd0);
        check("t5_rst_ready", 32'(in_ready), 32'd0);
        check("t5_no_pair", 32'(got_q.size()), 32'd0);
        reset = 1'b0;
        got_q.delete();
        done_q.delete();
        step();
        out_ready = 1'b1;
        push(3, 8'h66, 1);
        push(1, 8'h77, 1);
        wait_quiet("t5");
        exp_q.push_back(pk(8'h77, 1, 1, 1));
        exp_q.push_back(pk(8'h66, 1, 1, 3));
        check_pairs("t5");
        check_order("t5", '{1, 3});

        // back-to-back single-byte packets on ch1
        push(1, 8'h7E, 1);
        push(1, 8'h7F, 1);
        n = 0;
        while (!in_ready[1] && n < 20) begin step(); n++; end
        check("t6_grant1", 32'(in_ready), 32'b0010);
        step();
        check("t6_gap", 32'(in_ready), 32'd0);
        step();
        check("t6_grant2", 32'(in_ready), 32'b0010);
        wait_quiet("t6");
        exp_q.push_back(pk(8'h7E, 1, 1, 1));
        exp_q.push_back(pk(8'h7F, 1, 1, 1));
        check_pairs("t6");
        check_order("t6", '{1, 1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
